// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch control and time register around an external 4-digit BCD adder.
// Optional macro STOPWATCH_AUTO_STOP_EN: stop at 99.99 instead of wrapping.
module bcd_stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_start_stop,
   input  logic        btn_lap,
   input  logic        btn_clear,
   output logic [15:0] add_q,
   output logic [15:0] add_b,
   output logic        add_cin,
   input  logic [15:0] add_s,
   input  logic        add_cout,
   output logic [15:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, state_n;
   logic [PW-1:0] pre, pre_n;
   logic [15:0]   count, count_n;
   logic [15:0]   lap_reg, lap_reg_n;
   logic          lap_on_n, ovf_n;
   logic          tick;
   logic          auto_hold;

   logic [2:0] btn_raw, s1, s2, prev, pulse;
   logic       ss_p, lap_p, clr_p;

   assign btn_raw = {btn_clear, btn_lap, btn_start_stop};
   assign pulse   = s2 & ~prev;
   assign ss_p    = pulse[0];
   assign lap_p   = pulse[1];
   assign clr_p   = pulse[2];

   assign add_q   = count;
   assign add_cin = 1'b0;

   // After an auto-stop, start/stop cannot resume until clear
`ifdef STOPWATCH_AUTO_STOP_EN
   assign auto_hold = overflow;
`else
   assign auto_hold = 1'b0;
`endif

   // Next-state for the control FSM and the time/lap registers
   always_comb begin
      state_n   = state;
      pre_n     = pre;
      count_n   = count;
      lap_on_n  = lap_active;
      lap_reg_n = lap_reg;
      ovf_n     = overflow;
      tick      = 1'b0;
      case (state)
         RUN: begin
            tick  = (pre == PMAX);
            pre_n = tick ? '0 : pre + PW'(1);
            if (tick) begin
               if (add_cout) ovf_n = 1'b1;
`ifdef STOPWATCH_AUTO_STOP_EN
               if (add_cout) state_n = PAUSE;
               else          count_n = add_s;
`else
               count_n = add_s;
`endif
            end
            // Lap captures the pre-increment count
            if (lap_p) begin
               lap_on_n = ~lap_active;
               if (!lap_active) lap_reg_n = count;
            end
            if (ss_p) state_n = PAUSE;
         end
         default: begin
            if (lap_p) lap_on_n = 1'b0;
            if (clr_p) begin
               state_n  = IDLE;
               count_n  = '0;
               pre_n    = '0;
               lap_on_n = 1'b0;
               ovf_n    = 1'b0;
            end else if (ss_p && !auto_hold) begin
               state_n = RUN;
               if (state == IDLE) pre_n = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1         <= '0;
         s2         <= '0;
         prev       <= '0;
         state      <= IDLE;
         pre        <= '0;
         count      <= '0;
         lap_reg    <= '0;
         lap_active <= 1'b0;
         overflow   <= 1'b0;
         add_b      <= '0;
         running    <= 1'b0;
         disp_bcd   <= '0;
      end else begin
         s1         <= btn_raw;
         s2         <= s1;
         prev       <= s2;
         state      <= state_n;
         pre        <= pre_n;
         count      <= count_n;
         lap_reg    <= lap_reg_n;
         lap_active <= lap_on_n;
         overflow   <= ovf_n;
         add_b      <= (state_n == RUN) ? 16'h0001 : 16'h0000;
         running    <= (state_n == RUN);
         disp_bcd   <= lap_on_n ? lap_reg_n : count_n;
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl with a behavioural BCD adder and
// an integer-count reference model of the stopwatch.
module tb_bcd_stopwatch_ctrl;

   localparam int unsigned TD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bss = 1'b0, blap = 1'b0, bclr = 1'b0;
   logic [15:0] add_q, add_b, add_s, disp_bcd;
   logic        add_cin, add_cout, running, lap_active, overflow;

   int n_chk = 0;
   int n_fail = 0;

   bcd_stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_start_stop(bss), .btn_lap(blap), .btn_clear(bclr),
      .add_q(add_q), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout),
      .disp_bcd(disp_bcd), .running(running),
      .lap_active(lap_active), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [15:0] v);
      return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] int2bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   // Behavioural stand-in for the team's BCD adder
   int sum_i;
   always_comb begin
      sum_i    = bcd2int(add_q) + bcd2int(add_b) + int'(add_cin);
      add_cout = (sum_i >= 10000);
      add_s    = int2bcd(sum_i % 10000);
   end

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] b;
      logic        cin;
      logic [15:0] disp;
      logic        run;
      logic        lap;
      logic        ovf;
   } obs_t;

   obs_t exp_q[$];

   // Reference model: mode 0 idle, 1 running, 2 paused; count kept as integer
   int       m_mode = 0, m_pre = 0, m_cnt = 0, m_lapv = 0;
   bit       m_lap = 0, m_ovf = 0;
   bit [2:0] hist[$] = '{3'b0, 3'b0, 3'b0};

   function automatic obs_t model_obs();
      obs_t o;
      o.q    = int2bcd(m_cnt);
      o.b    = (m_mode == 1) ? 16'h0001 : 16'h0000;
      o.cin  = 1'b0;
      o.disp = m_lap ? int2bcd(m_lapv) : int2bcd(m_cnt);
      o.run  = (m_mode == 1);
      o.lap  = m_lap;
      o.ovf  = m_ovf;
      return o;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_mode = 0; m_pre = 0; m_cnt = 0; m_lapv = 0; m_lap = 0; m_ovf = 0;
         hist = '{3'b0, 3'b0, 3'b0};
         exp_q.delete();
         exp_q.push_back(model_obs());
      end else begin
         bit [2:0] p;
         bit       auto_stop;
         hist.push_front({bclr, blap, bss});
         // A press acts on the third edge after the raw level rises
         p = hist[2] & ~hist[3];
         void'(hist.pop_back());
`ifdef STOPWATCH_AUTO_STOP_EN
         auto_stop = 1'b1;
`else
         auto_stop = 1'b0;
`endif
         if (m_mode == 1) begin
            bit tk;
            tk = (m_pre == int'(TD) - 1);
            m_pre = tk ? 0 : m_pre + 1;
            if (p[1]) begin
               if (!m_lap) m_lapv = m_cnt;
               m_lap = !m_lap;
            end
            if (tk) begin
               if (m_cnt == 9999) begin
                  m_ovf = 1;
                  if (auto_stop) m_mode = 2;
                  else m_cnt = 0;
               end else begin
                  m_cnt = m_cnt + 1;
               end
            end
            if (p[0]) m_mode = 2;
         end else begin
            if (p[1]) m_lap = 0;
            if (p[2]) begin
               m_mode = 0; m_cnt = 0; m_pre = 0; m_lap = 0; m_ovf = 0;
            end else if (p[0] && !(auto_stop && m_ovf)) begin
               if (m_mode == 0) m_pre = 0;
               m_mode = 1;
            end
         end
         exp_q.push_back(model_obs());
      end
   end

   // Monitor: compare every cycle's outputs against the queued expectation
   initial forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
         obs_t e, a;
         e = exp_q.pop_front();
         a = '{add_q, add_b, add_cin, disp_bcd, running, lap_active, overflow};
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t got q=%h b=%h cin=%b disp=%h run=%b lap=%b ovf=%b want q=%h b=%h cin=%b disp=%h run=%b lap=%b ovf=%b",
                     $time, a.q, a.b, a.cin, a.disp, a.run, a.lap, a.ovf,
                     e.q, e.b, e.cin, e.disp, e.run, e.lap, e.ovf);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic wait_q(input logic [15:0] v, input int budget, input string nm);
      int n = 0;
      while (add_q !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(add_q), 32'(v));
   endtask

   task automatic press(input logic [2:0] m, input int hold);
      @(negedge clk);
      {bclr, blap, bss} = m;
      repeat (hold) @(negedge clk);
      {bclr, blap, bss} = 3'b000;
      repeat (4) @(negedge clk);
   endtask

   function automatic logic [31:0] all_or();
      return 32'({add_q | add_b | disp_bcd, add_cin, running, lap_active, overflow});
   endfunction

   task automatic reset_pulse(input string nm);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk(nm, all_or(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs_zero", all_or(), 32'h0);
      rst_n = 1'b1;

      // Start latency: action on the third edge
      @(negedge clk);
      bss = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("start_edge2_idle", 32'(running), 32'h0);
      @(posedge clk);
      #1 chk("start_edge3_running", 32'(running), 32'h1);
      chk("start_add_b", 32'(add_b), 32'h1);
      @(negedge clk);
      bss = 1'b0;

      wait_q(16'h0012, 200, "reach_0012");
      reset_pulse("async_reset_mid_run");

      // Count rate from a fresh start
      @(negedge clk);
      bss = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("restart_running", 32'(running), 32'h1);
      @(negedge clk);
      bss = 1'b0;
      repeat (40) @(posedge clk);
      #1 chk("count_40", 32'(add_q), 32'h0010);
      chk("disp_40", 32'(disp_bcd), 32'h0010);
      repeat (360) @(posedge clk);
      #1 chk("count_400", 32'(add_q), 32'h0100);

      // Random button traffic
      for (int i = 0; i < 250; i++) begin
         logic [2:0] m;
         m = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 3) != 0) m[2] = 1'b0;
         if (m == 3'b000) m = 3'b010;
         press(m, int'($urandom_range(1, 5)));
         repeat ($urandom_range(0, 25)) @(negedge clk);
         if (i == 125) reset_pulse("async_reset_random");
      end

      // Overflow at 99.99
      reset_pulse("async_reset_pre_ovf");
      press(3'b001, 1);
      wait_q(16'h9999, 45000, "reach_9999");
      repeat (TD + 1) @(negedge clk);
      chk("overflow_set", 32'(overflow), 32'h1);
`ifdef STOPWATCH_AUTO_STOP_EN
      chk("ovf_auto_stopped", 32'(running), 32'h0);
      chk("ovf_count_held", 32'(add_q), 32'h9999);
      press(3'b001, 1);
      chk("ovf_restart_blocked", 32'(running), 32'h0);
`else
      chk("ovf_still_running", 32'(running), 32'h1);
      chk("ovf_count_wrapped", 32'(add_q), 32'h0000);
      press(3'b100, 2);
      repeat (2 * TD) @(negedge clk);
      chk("clear_in_run_ignored", 32'(running), 32'h1);
      press(3'b001, 1);
      chk("stop_paused", 32'(running), 32'h0);
`endif
      press(3'b100, 1);
      chk("clear_count", 32'(add_q), 32'h0);
      chk("clear_overflow", 32'(overflow), 32'h0);
      chk("clear_lap", 32'(lap_active), 32'h0);

      // Clear and start together from PAUSE
      press(3'b001, 1);
      repeat (10) @(negedge clk);
      press(3'b001, 1);
      press(3'b101, 1);
      repeat (10) @(negedge clk);
      chk("clear_start_idle", 32'(running), 32'h0);
      chk("clear_start_count", 32'(add_q), 32'h0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
